ahb_lite_mem_slave: RTL
=======================

// Module: ahb_lite_mem_slave
// PURPOSE
//  Parametrised AHB-Lite slave: byte-addressed, word-organised flop memory; generalises the bus typedefs into a
//  full-featured target. Adds configurable data/address width, byte-lane writes, two-cycle ERROR response and
//  optional programmable wait states. Sits behind the decoder/mux; it is the DUT target for the UVM AHB env.
// PARAMETERS
//  SLAVE_DATAWIDTH  32  data bus width; one of 32/64/128; BYTES = SLAVE_DATAWIDTH/8
//  SLAVE_ADDRWIDTH  10  log2(memory depth in words); DEPTH = 2**SLAVE_ADDRWIDTH
//  ADDRWIDTH        32  HADDR width
//  WAIT_STATES      0   wait cycles per NONSEQ/SEQ data phase (0..15); used only with AHB_SLAVE_WAIT_EN
// PORTS
//  HCLK       in   1                 bus clock; all state on rising edge
//  HRESETn    in   1                 asynchronous, active-low reset
//  HSEL       in   1                 slave select (address phase)
//  HADDR      in   ADDRWIDTH         byte address (address phase)
//  HTRANS     in   2                 HTRANS_TYPE: IDLE/BUSY/NONSEQ/SEQ
//  HWRITE     in   1                 HWRITE_TYPE: READ/WRITE
//  HSIZE      in   3                 transfer size, 2**HSIZE bytes
//  HBURST     in   3                 HBURST_TYPE; informational only, not decoded
//  HWDATA     in   SLAVE_DATAWIDTH   write data (data phase)
//  HREADY     in   1                 bus ready; address phase sampled only when 1
//  HREADYOUT  out  1                 slave ready
//  HRESP      out  1                 HRESP_TYPE: OKAY/ERROR
//  HRDATA     out  SLAVE_DATAWIDTH   read data (data phase)
// BEHAVIOUR
//  - Reset: HREADYOUT=1, HRESP=OKAY, HRDATA=0, FSM=ST_READY, wait counter=0, all memory words=0.
//  - Address phase accepted when HSEL & HREADY & HTRANS in {NONSEQ,SEQ}. Registers HADDR/HWRITE/HSIZE for data phase.
//  - IDLE/BUSY or !HSEL: data phase is zero-wait OKAY; no memory access.
//  - Error check at accept, pipelined with address: ERROR if any HADDR bit above word-index+byte-offset is nonzero,
//    or 2**HSIZE > BYTES, or HADDR not aligned to 2**HSIZE.
//  - FSM states: ST_READY, ST_WAIT, ST_ERR1, ST_ERR2.
//    ST_READY --accept&err--> ST_ERR1; --accept&!err&WAIT_STATES>0--> ST_WAIT; else stays.
//    ST_WAIT: HREADYOUT=0, HRESP=OKAY; counter decrements; ->ST_READY when it reaches 1.
//    ST_ERR1: HREADYOUT=0, HRESP=ERROR. Always ->ST_ERR2.
//    ST_ERR2: HREADYOUT=1, HRESP=ERROR. Then acts as ST_READY for the next accept.
//  - ERROR transfers never write memory. HRDATA=0 for ERROR reads.
//  - New address phases are not accepted while HREADYOUT=0. The master may drop to IDLE in ST_ERR2; that is accepted normally.
//  - Write commits on the HCLK edge ending the data phase (HREADYOUT=1).
//    Only lanes [offset +: 2**HSIZE] are written (little-endian).
//  - Read: HRDATA = mem[registered index] (full word) while HREADYOUT=1 in a read data phase; 0 otherwise.
//    The read is combinational from the array.
//  - Write followed immediately by a read of the same word returns the new data with zero wait (no hazard stall).
//  - HRESETn asserted mid-transfer: immediate return to the reset state. The in-flight write is discarded.
// CONFIGURATION
//  - AHB_SLAVE_WAIT_EN defined:
//    - each valid NONSEQ/SEQ data phase inserts WAIT_STATES cycles of HREADYOUT=0 before completing.
//    - ERROR phases get no extra waits; wait counter is $clog2(16) bits.
//  - Undefined: ST_WAIT and the counter are not built; WAIT_STATES is ignored; all OKAY transfers are zero-wait.
// STRUCTURE
//  - Package AHBpkg: HTRANS_TYPE, HBURST_TYPE, HSIZE_TYPE, HRESP_TYPE, HWRITE_TYPE.
//    Add SLV_STATE_T {ST_READY,ST_WAIT,ST_ERR1,ST_ERR2}.
//  - The SLAVE_DATAWIDTH/SLAVE_ADDRWIDTH defaults live there.
//  - One sub-module: ahb_byte_lane_dec (combinational). Inputs: HSIZE and byte offset.
//    Outputs: BYTES-bit lane mask and misalign/oversize error flag.
// TESTING
//  - Reset: HRESETn=0 at any time -> HREADYOUT=1, HRESP=OKAY, HRDATA=0; read of 0x0 after release returns 0.
//  - Word write/read:
//    - NONSEQ WRITE 0x10 with HWDATA=0xDEADBEEF, then NONSEQ READ 0x10 back-to-back -> HRDATA=0xDEADBEEF.
//    - Both transfers are zero-wait OKAY.
//  - Byte lanes: write word 0x0 with 0x11223344, then HSIZE=BYTE write 0xAA at 0x2 (HWDATA=0x00AA0000).
//    Read 0x0 -> 0x11AA3344.
//  - Error, out of range: NONSEQ 0x1000 (DEPTH=1024 words x4 B = 0x1000 limit) -> cycle1 HREADYOUT=0/ERROR.
//    Cycle2 HREADYOUT=1/ERROR. Memory unchanged.
//  - Error, misaligned: HSIZE=WORD at 0x2 -> two-cycle ERROR. Following IDLE -> OKAY.
//  - Waits (AHB_SLAVE_WAIT_EN, WAIT_STATES=2): INCR4 write 0x20..0x2C -> each beat 2 cycles HREADYOUT=0 then 1.
//    INCR4 read back -> same 4 words.

Source files
------------

// File: rtl/ahb_lite_mem_slave_pkg.sv
// AHB-Lite bus typedefs and slave FSM states shared by the memory slave and its testbench.
package AHBpkg;
  localparam int SLAVE_DATAWIDTH_DEFAULT = 32;
  localparam int SLAVE_ADDRWIDTH_DEFAULT = 10;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY   = 2'b01,
    NONSEQ = 2'b10,
    SEQ    = 2'b11
  } HTRANS_TYPE;

  typedef enum logic [2:0] {
    SINGLE, INCR, WRAP4, INCR4, WRAP8, INCR8, WRAP16, INCR16
  } HBURST_TYPE;

  typedef enum logic [2:0] {
    BYTE, HWORD, WORD, DWORD, QWORD, OWORD, HEXWORD, KBIT
  } HSIZE_TYPE;

  typedef enum logic {
    OKAY  = 1'b0,
    ERROR = 1'b1
  } HRESP_TYPE;

  typedef enum logic {
    READ  = 1'b0,
    WRITE = 1'b1
  } HWRITE_TYPE;

  typedef enum logic [1:0] {
    ST_READY, ST_WAIT, ST_ERR1, ST_ERR2
  } SLV_STATE_T;
endpackage

// File: rtl/ahb_lite_mem_slave_lane_dec.sv
// Byte-lane decoder: turns HSIZE and the byte offset within a word into a lane mask,
// flagging transfers wider than the bus or not aligned to their own size.
module ahb_byte_lane_dec #(
  parameter int BYTES = 4,
  parameter int OFFW  = $clog2(BYTES)
) (
  input  logic [2:0]       hsize,
  input  logic [OFFW-1:0]  offset,
  output logic [BYTES-1:0] lane_mask,
  output logic             size_err
);
  logic [7:0] nbytes;
  logic       oversize;
  logic       misalign;

  always_comb begin
    nbytes    = 8'd1 << hsize;
    oversize  = (int'(nbytes) > BYTES);
    misalign  = ((8'(offset) & (nbytes - 8'd1)) != 8'd0);
    size_err  = oversize | misalign;
    lane_mask = '0;
    for (int i = 0; i < BYTES; i++) begin
      lane_mask[i] = (i >= int'(offset)) && (i < int'(offset) + int'(nbytes));
    end
  end
endmodule

// File: rtl/ahb_lite_mem_slave.sv
// AHB-Lite flop-memory slave with byte-lane writes and two-cycle ERROR response.
// Define AHB_SLAVE_WAIT_EN to insert WAIT_STATES wait cycles into every OKAY NONSEQ/SEQ data phase.
module ahb_lite_mem_slave
  import AHBpkg::*;
#(
  parameter int SLAVE_DATAWIDTH = SLAVE_DATAWIDTH_DEFAULT,
  parameter int SLAVE_ADDRWIDTH = SLAVE_ADDRWIDTH_DEFAULT,
  parameter int ADDRWIDTH       = 32,
  parameter int WAIT_STATES     = 0
) (
  input  logic                       HCLK,
  input  logic                       HRESETn,
  input  logic                       HSEL,
  input  logic [ADDRWIDTH-1:0]       HADDR,
  input  logic [1:0]                 HTRANS,
  input  logic                       HWRITE,
  input  logic [2:0]                 HSIZE,
  input  logic [2:0]                 HBURST,
  input  logic [SLAVE_DATAWIDTH-1:0] HWDATA,
  input  logic                       HREADY,
  output logic                       HREADYOUT,
  output logic                       HRESP,
  output logic [SLAVE_DATAWIDTH-1:0] HRDATA
);
  localparam int BYTES  = SLAVE_DATAWIDTH / 8;
  localparam int OFFW   = $clog2(BYTES);
  localparam int DEPTH  = 2 ** SLAVE_ADDRWIDTH;
  localparam int HI_LSB = SLAVE_ADDRWIDTH + OFFW;
  localparam logic [3:0] WAIT_CNT = 4'(WAIT_STATES);

  SLV_STATE_T                 state_q, state_d;
  logic                       dp_vld_q, dp_vld_d;
  logic                       dp_wr_q, dp_wr_d;
  logic [SLAVE_ADDRWIDTH-1:0] dp_idx_q, dp_idx_d;
  logic [BYTES-1:0]           dp_mask_q, dp_mask_d;
  logic [SLAVE_DATAWIDTH-1:0] mem_q [DEPTH];
  logic [SLAVE_DATAWIDTH-1:0] mem_word_d;

  logic [OFFW-1:0]            a_off;
  logic [SLAVE_ADDRWIDTH-1:0] a_idx;
  logic [BYTES-1:0]           a_mask;
  logic                       size_err;
  logic                       range_err;
  logic                       a_err;
  logic                       accept;
  logic                       hreadyout;
  logic                       mem_we;
  logic                       unused_sig;

`ifdef AHB_SLAVE_WAIT_EN
  logic [$clog2(16)-1:0]      wcnt_q, wcnt_d;
  assign unused_sig = ^HBURST;
`else
  assign unused_sig = ^{HBURST, WAIT_CNT};
`endif

  assign a_off     = HADDR[OFFW-1:0];
  assign a_idx     = HADDR[HI_LSB-1:OFFW];
  assign range_err = (HADDR >> HI_LSB) != '0;
  assign a_err     = range_err | size_err;

  ahb_byte_lane_dec #(
    .BYTES (BYTES),
    .OFFW  (OFFW)
  ) u_lane_dec (
    .hsize     (HSIZE),
    .offset    (a_off),
    .lane_mask (a_mask),
    .size_err  (size_err)
  );

  // Ready/response are pure functions of the state, so accept never loops back through them.
  assign hreadyout = !(state_q == ST_WAIT || state_q == ST_ERR1);
  assign HREADYOUT = hreadyout;
  assign HRESP     = (state_q == ST_ERR1 || state_q == ST_ERR2) ? ERROR : OKAY;
  assign accept    = HSEL && HREADY && hreadyout &&
                     (HTRANS == NONSEQ || HTRANS == SEQ);

  always_comb begin
    state_d = state_q;
`ifdef AHB_SLAVE_WAIT_EN
    wcnt_d  = wcnt_q;
`endif
    case (state_q)
      ST_READY, ST_ERR2: begin
        state_d = ST_READY;
        if (accept) begin
          if (a_err) begin
            state_d = ST_ERR1;
          end
`ifdef AHB_SLAVE_WAIT_EN
          else if (WAIT_CNT != 4'd0) begin
            state_d = ST_WAIT;
            wcnt_d  = WAIT_CNT;
          end
`endif
        end
      end
      ST_WAIT: begin
`ifdef AHB_SLAVE_WAIT_EN
        if (wcnt_q <= 4'd1) state_d = ST_READY;
        else                wcnt_d  = wcnt_q - 4'd1;
`else
        state_d = ST_READY;
`endif
      end
      ST_ERR1: state_d = ST_ERR2;
      default: state_d = ST_READY;
    endcase
  end

  // Address phase -> data phase registers; only advance when the current data phase ends.
  always_comb begin
    dp_vld_d  = dp_vld_q;
    dp_wr_d   = dp_wr_q;
    dp_idx_d  = dp_idx_q;
    dp_mask_d = dp_mask_q;
    if (HREADY && hreadyout) begin
      dp_vld_d  = accept && !a_err;
      dp_wr_d   = HWRITE;
      dp_idx_d  = a_idx;
      dp_mask_d = a_mask;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q  <= ST_READY;
      dp_vld_q <= 1'b0;
`ifdef AHB_SLAVE_WAIT_EN
      wcnt_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      dp_vld_q <= dp_vld_d;
`ifdef AHB_SLAVE_WAIT_EN
      wcnt_q   <= wcnt_d;
`endif
    end
  end

  always_ff @(posedge HCLK) begin
    dp_wr_q   <= dp_wr_d;
    dp_idx_q  <= dp_idx_d;
    dp_mask_q <= dp_mask_d;
  end

  // Write data arrives in the data phase; merge enabled lanes over the stored word.
  always_comb begin
    mem_we     = hreadyout && dp_vld_q && dp_wr_q;
    mem_word_d = mem_q[dp_idx_q];
    for (int b = 0; b < BYTES; b++) begin
      if (dp_mask_q[b]) mem_word_d[b*8 +: 8] = HWDATA[b*8 +: 8];
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (mem_we) begin
      mem_q[dp_idx_q] <= mem_word_d;
    end
  end

  assign HRDATA = (hreadyout && dp_vld_q && !dp_wr_q) ? mem_q[dp_idx_q] : '0;
endmodule
